// File: rtl/exp_golomb_sched_pkg.sv
// exp_golomb_sched_pkg: decoder mode codes and sequencer state encodings
package exp_golomb_sched_pkg;
  localparam logic [1:0] EG_RST = 2'b00;
  localparam logic [1:0] EG_UE  = 2'b01;
  localparam logic [1:0] EG_SE  = 2'b10;
  localparam logic [1:0] EG_TE  = 2'b11;
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WAIT    = 3'd1;
  localparam logic [2:0] ST_CONSUME = 3'd2;
  localparam logic [2:0] ST_RSP     = 3'd3;
  localparam logic [2:0] ST_ERR     = 3'd4;
  function automatic logic legal_mode(input logic [1:0] m);
    return m == EG_UE || m == EG_SE || m == EG_TE;
  endfunction
endpackage

// File: rtl/exp_golomb_sched_rr_arbiter.sv
// exp_golomb_sched_rr_arbiter: picks the first request at or after ptr, wrapping
module exp_golomb_sched_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDXW = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDXW-1:0] i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IDXW-1:0] o_idx
);
  always_comb begin
    o_idx = '0;
    // scan from farthest to nearest so the closest request to ptr wins
    for (int k = NREQ - 1; k >= 0; k--)
      if (i_req[(int'(i_ptr) + k) % NREQ]) o_idx = IDXW'((int'(i_ptr) + k) % NREQ);
    o_grant = |i_req ? NREQ'(1) << o_idx : '0;
  end
endmodule

// File: rtl/exp_golomb_sched.sv
// exp_golomb_sched: round-robin sequencer sharing one Exp-Golomb decoder between parsers
module exp_golomb_sched
  import exp_golomb_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDXW = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [2*NREQ-1:0] req_mode,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [7:0]        rsp_data,
  output logic              rsp_err,
  output logic              busy,
  output logic [1:0]        eg_sel,
  input  logic [3:0]        eg_len,
  input  logic [7:0]        eg_value,
  input  logic              ho_valid,
  input  logic [4:0]        win_bits,
  output logic              consume_valid,
  output logic [3:0]        consume_len,
  input  logic              consume_ready
);
  logic [2:0]      r_state;
  logic [IDXW-1:0] r_ptr, r_idx;
  logic [1:0]      r_mode;
  logic [3:0]      r_len;
  logic [7:0]      r_value;
  logic [NREQ-1:0] w_grant;
  logic [IDXW-1:0] w_idx;
  logic [1:0]      w_mode;
  logic            w_dec, w_done;

  exp_golomb_sched_rr_arbiter #(.NREQ(NREQ), .IDXW(IDXW)) u_arb (
    .i_req  (req_valid),
    .i_ptr  (r_ptr),
    .o_grant(w_grant),
    .o_idx  (w_idx)
  );

  assign w_mode = req_mode[2*w_idx +: 2];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_idx   <= '0;
      r_mode  <= EG_RST;
      r_len   <= '0;
      r_value <= '0;
    end else if (flush) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (|w_grant) begin
          r_idx   <= w_idx;
          r_mode  <= w_mode;
          r_state <= legal_mode(w_mode) ? ST_WAIT : ST_ERR;
        end
        ST_WAIT: if (ho_valid && win_bits >= {1'b0, eg_len}) begin
          r_len   <= eg_len;
          r_value <= eg_value;
          r_state <= ST_CONSUME;
        end else if (win_bits == 5'd16 && !ho_valid) begin
          // a full window with no leading one means the codeword exceeds 15 bits
          r_state <= ST_ERR;
        end
        ST_CONSUME: if (consume_ready) r_state <= ST_RSP;
        ST_RSP, ST_ERR: begin
          r_ptr   <= r_idx == IDXW'(NREQ - 1) ? '0 : r_idx + 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_dec         = r_state == ST_WAIT || r_state == ST_CONSUME;
  assign w_done        = r_state == ST_RSP || r_state == ST_ERR;
  assign busy          = r_state != ST_IDLE;
  assign eg_sel        = w_dec ? r_mode : EG_RST;
  assign consume_valid = r_state == ST_CONSUME && !flush;
  assign consume_len   = r_state == ST_CONSUME ? r_len : '0;
  assign rsp_valid     = w_done ? NREQ'(1) << r_idx : '0;
  assign rsp_data      = r_state == ST_RSP ? r_value : '0;
  assign rsp_err       = r_state == ST_ERR;
endmodule

// File: tb/tb_exp_golomb_sched.sv
// tb_exp_golomb_sched: directed and random element requests checked against a transaction model
module tb_exp_golomb_sched;
  logic       clk = 0, reset_n = 0, flush = 0;
  logic [3:0] req_valid = 0;
  logic [7:0] req_mode = 0;
  logic [3:0] rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_err, busy;
  logic [1:0] eg_sel;
  logic [3:0] eg_len = 0;
  logic [7:0] eg_value = 0;
  logic       ho_valid = 0;
  logic [4:0] win_bits = 0;
  logic       consume_valid;
  logic [3:0] consume_len;
  logic       consume_ready = 0;

  int n_checks = 0, n_err = 0;
  int m_ptr = 0;
  logic [3:0] reqs = 0;
  logic [7:0] modes = 0;

  exp_golomb_sched dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .req_valid(req_valid), .req_mode(req_mode),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .eg_sel(eg_sel), .eg_len(eg_len), .eg_value(eg_value),
    .ho_valid(ho_valid), .win_bits(win_bits),
    .consume_valid(consume_valid), .consume_len(consume_len), .consume_ready(consume_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_win(input int c, input int wt, input int st, input logic [4:0] short_w,
                         input logic [4:0] full_w, input bit errw);
    if (errw) begin
      ho_valid = 0;
      win_bits = 16;
    end else if (c <= wt) begin
      ho_valid = 1'($urandom_range(0, 1));
      win_bits = short_w;
    end else begin
      ho_valid = 1;
      win_bits = full_w;
    end
    consume_ready = c >= 2 + wt + st;
  endtask

  // called just after a posedge with the DUT idle; reqs must be nonzero
  task automatic run_op(input logic [3:0] len, input logic [7:0] val, input int wt,
                        input logic [4:0] short_w, input logic [4:0] full_w, input int st, input bit errw);
    int c, idx, lat, ncv, nsel, bad;
    logic [1:0] md;
    bit illegal, fail;
    idx = 0;
    for (int k = 3; k >= 0; k--) if (reqs[(m_ptr + k) % 4]) idx = (m_ptr + k) % 4;
    md = modes[2*idx +: 2];
    illegal = md == 2'b00;
    fail = illegal || errw;
    lat = illegal ? 1 : errw ? 2 : 3 + wt + st;
    req_valid = reqs; req_mode = modes; eg_len = len; eg_value = val;
    c = 0; ncv = 0; nsel = 0; bad = 0;
    set_win(c, wt, st, short_w, full_w, errw);
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_rsp_valid", rsp_valid, 0);
    chk("idle_rsp_data_err", {rsp_data, rsp_err}, 0);
    chk("idle_eg_sel", eg_sel, 0);
    chk("idle_consume", {consume_valid, consume_len}, 0);
    while (rsp_valid == 0 && c < 60) begin
      if (consume_valid) begin ncv++; if (consume_len !== len) bad++; end
      if (eg_sel != 0) begin nsel++; if (eg_sel !== md) bad++; end
      @(posedge clk); #1;
      c++;
      req_valid = 4'($urandom);
      req_mode = 8'($urandom);
      set_win(c, wt, st, short_w, full_w, errw);
      @(negedge clk);
    end
    chk("latency", c, lat);
    chk("rsp_valid", rsp_valid, 32'(1) << idx);
    chk("rsp_data", rsp_data, fail ? 0 : val);
    chk("rsp_err", rsp_err, fail);
    chk("rsp_busy", busy, 1);
    chk("consume_cycles", ncv, fail ? 0 : st + 1);
    chk("sel_cycles", nsel, illegal ? 0 : errw ? 1 : wt + st + 2);
    chk("sel_len_steady", bad, 0);
    m_ptr = (idx + 1) % 4;
    @(posedge clk); #1;
    reqs[idx] = 0;
    req_valid = reqs; req_mode = modes; consume_ready = 0;
  endtask

  // brings the current winner into CONSUME with the buffer not ready; ends mid-cycle
  task automatic to_consume();
    req_valid = reqs; req_mode = modes;
    eg_len = 4'd7; eg_value = 8'h5A; ho_valid = 1; win_bits = 16; consume_ready = 0;
    repeat (2) begin @(posedge clk); #1; req_valid = 4'($urandom); end
    @(negedge clk);
    chk("pre_consume_valid", consume_valid, 1);
    chk("pre_consume_len", consume_len, 7);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp", {rsp_valid, rsp_data, rsp_err}, 0);
    chk("rst_busy_sel", {busy, eg_sel}, 0);
    chk("rst_consume", {consume_valid, consume_len}, 0);
    @(posedge clk); #1;
    reset_n = 1;
    modes = 8'b01_10_11_01;
    reqs = 4'b1111;
    repeat (4) run_op(4'd3, 8'h11, 0, 0, 16, 0, 0);
    for (int n = 0; n < 4; n++) begin
      reqs |= 4'b0101;
      run_op(4'd7, 8'(n + 8'h20), 0, 0, 16, 0, 0);
    end
    modes = 8'h55; reqs = 4'b0001;
    run_op(4'd5, 8'h03, 0, 0, 16, 0, 0);
    modes = 8'hAA; reqs = 4'b0010;
    run_op(4'd5, 8'hFE, 3, 3, 5, 0, 0);
    reqs = 4'b1000;
    run_op(4'd7, 8'hAA, 0, 0, 16, 0, 1);
    modes = 8'h54; reqs = 4'b0001;
    run_op(4'd3, 8'h77, 0, 0, 16, 0, 0);
    modes = 8'hFF; reqs = 4'b0100;
    run_op(4'd1, 8'h01, 0, 0, 1, 0, 0);
    reqs = 4'b0010;
    run_op(4'd9, 8'h40, 0, 0, 16, 4, 0);
    reqs = 4'b0100;
    to_consume();
    flush = 1; consume_ready = 1;
    #1 chk("flush_consume_valid", consume_valid, 0);
    @(posedge clk); #1;
    flush = 0; consume_ready = 0;
    run_op(4'd3, 8'h02, 0, 0, 16, 0, 0);
    reqs = 4'b1100;
    to_consume();
    reset_n = 0;
    @(posedge clk); #1;
    reset_n = 1;
    m_ptr = 0;
    run_op(4'd4, 8'h66, 1, 2, 9, 1, 0);
    run_op(4'd4, 8'h67, 0, 0, 16, 0, 0);
    for (int n = 0; n < 40; n++) begin
      logic [3:0] len;
      reqs |= 4'($urandom);
      if (reqs == 0) reqs = 4'b0001;
      for (int r = 0; r < 4; r++)
        modes[2*r +: 2] = $urandom_range(0, 9) == 0 ? 2'b00 : 2'($urandom_range(1, 3));
      len = 4'($urandom_range(1, 15));
      run_op(len, 8'($urandom), $urandom_range(0, 3), 5'($urandom_range(0, int'(len) - 1)),
             5'($urandom_range(int'(len), 16)), $urandom_range(0, 3), $urandom_range(0, 9) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule
